uart_readback_tx: RTL and testbench

- UART 8N1 transmitter that sends the GPU's host-loaded register frame (vertices, normal, light, VP matrix, render_mode) back to the PC for link verification.
- It is the transmit counterpart of the input-assembly UART receiver.
- On a start pulse it walks register byte indices 0..NUM_BYTES-1 through a read port and serializes each byte LSB-first on tx.
- An optional sync byte is sent first.

---
 rtl/gpu_uart_pkg.sv | 36 +++
 rtl/uart_readback_tx_if.sv | 31 +++
 rtl/uart_tx_serializer.sv | 126 ++++++++++++
 rtl/uart_readback_tx.sv | 125 ++++++++++++
 tb/tb_uart_readback_tx.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpu_uart_pkg.sv
// Shared definitions for the GPU host UART link: the receiver that
// assembles the register frame and the readback transmitter that echoes it.
package gpu_uart_pkg;

    // 50 MHz system clock divided down to 115200 baud.
    localparam int CLKS_PER_BIT_DEFAULT = 434;

    // Header byte that marks the start of a readback frame.
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Register bytes in one host frame: vertices, normal, light, VP matrix
    // and render_mode. The receiver assembles the same count.
    localparam int FRAME_BYTES = 60;

    // Per-byte line states of the 8N1 transmitter.
    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_LOAD  = 3'd1,
        TX_START = 3'd2,
        TX_DATA  = 3'd3,
        TX_STOP  = 3'd4
    } tx_state_e;

    // Frame-level sequencing states of the readback transmitter.
    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_LOAD = 2'd1,
        SEQ_SEND = 2'd2
    } seq_state_e;

    // Bytes that go out on the line for one frame, header included.
    function automatic int frame_len(input int num_bytes, input int send_sync);
        return num_bytes + ((send_sync != 0) ? 1 : 0);
    endfunction

endpackage

// File: rtl/uart_readback_tx_if.sv
// Link between the readback transmitter, its requester and the register
// file read mux. The master side issues start and returns register bytes;
// the slave side is the transmitter.
interface uart_readback_tx_if;

    logic       start;
    logic [6:0] rd_idx;
    logic [7:0] rd_data;
    logic       tx;
    logic       busy;
    logic       done;

    modport master (
        output start,
        output rd_data,
        input  rd_idx,
        input  tx,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  rd_data,
        output rd_idx,
        output tx,
        output busy,
        output done
    );

endinterface

// File: rtl/uart_tx_serializer.sv
// 8N1 shift/baud engine. A load pulse captures a byte and starts a start
// bit immediately, even from the last stop cycle, so consecutive bytes are
// sent back-to-back. tx is the registered image of the current line state
// and therefore trails the state by one clock.
module uart_tx_serializer
    import gpu_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_byte,
    output logic       tx,
    output logic       last_stop_cycle
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [BAUD_W-1:0] BAUD_ZERO = BAUD_W'(0);

    tx_state_e         state_r;
    tx_state_e         state_s;
    logic [BAUD_W-1:0] baud_r;
    logic [BAUD_W-1:0] baud_s;
    logic [2:0]        bit_r;
    logic [2:0]        bit_s;
    logic [7:0]        shift_r;
    logic [7:0]        shift_s;
    logic              line_s;
    logic              tx_r;
    logic              last_stop_r;
    logic              baud_wrap_s;

    assign baud_wrap_s = (baud_r == BAUD_LAST);

    // Next line state, baud count, bit count and shift contents.
    always_comb begin
        state_s = state_r;
        baud_s  = baud_r;
        bit_s   = bit_r;
        shift_s = shift_r;
        if (load) begin
            state_s = TX_START;
            baud_s  = BAUD_ZERO;
            bit_s   = 3'd0;
            shift_s = load_byte;
        end else begin
            case (state_r)
                TX_IDLE: begin
                    state_s = TX_IDLE;
                end
                TX_START: begin
                    if (baud_wrap_s) begin
                        state_s = TX_DATA;
                        baud_s  = BAUD_ZERO;
                        bit_s   = 3'd0;
                    end else begin
                        baud_s = baud_r + BAUD_ONE;
                    end
                end
                TX_DATA: begin
                    if (baud_wrap_s) begin
                        baud_s  = BAUD_ZERO;
                        shift_s = {1'b0, shift_r[7:1]};
                        if (bit_r == 3'd7) begin
                            state_s = TX_STOP;
                            bit_s   = 3'd0;
                        end else begin
                            bit_s = bit_r + 3'd1;
                        end
                    end else begin
                        baud_s = baud_r + BAUD_ONE;
                    end
                end
                TX_STOP: begin
                    if (baud_wrap_s) begin
                        state_s = TX_IDLE;
                        baud_s  = BAUD_ZERO;
                    end else begin
                        baud_s = baud_r + BAUD_ONE;
                    end
                end
                default: begin
                    state_s = TX_IDLE;
                    baud_s  = BAUD_ZERO;
                    bit_s   = 3'd0;
                end
            endcase
        end
    end

    // Line level for the current state; data bits go out LSB first.
    always_comb begin
        line_s = 1'b1;
        case (state_r)
            TX_START: line_s = 1'b0;
            TX_DATA:  line_s = shift_r[0];
            default:  line_s = 1'b1;
        endcase
    end

    // State registers, registered line output and last-stop-cycle flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= TX_IDLE;
            baud_r      <= BAUD_ZERO;
            bit_r       <= 3'd0;
            shift_r     <= 8'h00;
            tx_r        <= 1'b1;
            last_stop_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            baud_r      <= baud_s;
            bit_r       <= bit_s;
            shift_r     <= shift_s;
            tx_r        <= line_s;
            last_stop_r <= (state_s == TX_STOP) && (baud_s == BAUD_LAST);
        end
    end

    assign tx              = tx_r;
    assign last_stop_cycle = last_stop_r;

endmodule

// File: rtl/uart_readback_tx.sv
// Readback transmitter: on start, sends an optional sync byte followed by
// register bytes 0..NUM_BYTES-1 fetched through the read port, so the host
// can verify what the GPU actually latched. Byte framing is delegated to
// uart_tx_serializer; this level owns byte counting and read indexing.
module uart_readback_tx #(
    parameter int         CLKS_PER_BIT = gpu_uart_pkg::CLKS_PER_BIT_DEFAULT,
    parameter int         NUM_BYTES    = gpu_uart_pkg::FRAME_BYTES,
    parameter int         SEND_SYNC    = 1,
    parameter logic [7:0] SYNC_BYTE    = gpu_uart_pkg::SYNC_BYTE
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_readback_tx_if.slave    bus
);

    import gpu_uart_pkg::*;

    localparam bit         HAS_SYNC    = (SEND_SYNC != 0);
    localparam logic [6:0] TOTAL_BYTES = 7'(frame_len(NUM_BYTES, SEND_SYNC));

    seq_state_e state_r;
    logic [6:0] byte_cnt_r;
    logic [6:0] rd_idx_r;
    logic       busy_r;
    logic       done_r;

    logic [6:0] next_cnt_s;
    logic [6:0] next_idx_s;
    logic       more_s;
    logic       load_s;
    logic [7:0] load_byte_s;
    logic       last_stop_s;
    logic       ser_tx_s;

    // byte_cnt_r counts bytes already handed to the serializer; the next
    // register index is that count minus the header slot.
    assign next_cnt_s = byte_cnt_r + 7'd1;
    assign next_idx_s = HAS_SYNC ? byte_cnt_r : next_cnt_s;
    assign more_s     = (byte_cnt_r < TOTAL_BYTES);

    // Decide when the serializer takes a new byte and which byte it is.
    always_comb begin
        load_s      = 1'b0;
        load_byte_s = bus.rd_data;
        if (state_r == SEQ_LOAD) begin
            load_s = 1'b1;
        end else if ((state_r == SEQ_SEND) && last_stop_s && more_s) begin
            load_s = 1'b1;
        end else begin
            load_s = 1'b0;
        end
        if (HAS_SYNC && (byte_cnt_r == 7'd0)) begin
            load_byte_s = SYNC_BYTE;
        end else begin
            load_byte_s = bus.rd_data;
        end
    end

    uart_tx_serializer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_serializer (
        .clk             (clk),
        .reset           (reset),
        .load            (load_s),
        .load_byte       (load_byte_s),
        .tx              (ser_tx_s),
        .last_stop_cycle (last_stop_s)
    );

    // Frame sequencing: accept start, step byte count and read index, end frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= SEQ_IDLE;
            byte_cnt_r <= 7'd0;
            rd_idx_r   <= 7'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                SEQ_IDLE: begin
                    byte_cnt_r <= 7'd0;
                    // A start coinciding with the done pulse belongs to the
                    // frame that just ended and is dropped.
                    if (bus.start && !done_r) begin
                        state_r  <= SEQ_LOAD;
                        busy_r   <= 1'b1;
                        rd_idx_r <= 7'd0;
                    end
                end
                SEQ_LOAD: begin
                    state_r    <= SEQ_SEND;
                    byte_cnt_r <= next_cnt_s;
                    if (next_cnt_s < TOTAL_BYTES) begin
                        rd_idx_r <= next_idx_s;
                    end
                end
                SEQ_SEND: begin
                    if (last_stop_s) begin
                        if (more_s) begin
                            byte_cnt_r <= next_cnt_s;
                            if (next_cnt_s < TOTAL_BYTES) begin
                                rd_idx_r <= next_idx_s;
                            end
                        end else begin
                            state_r <= SEQ_IDLE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= SEQ_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rd_idx = rd_idx_r;
    assign bus.tx     = ser_tx_s;
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;

endmodule

// File: tb/tb_uart_readback_tx.sv
// Bench for uart_readback_tx: four instances (small sync, small no-sync,
// default parameters, 60-byte fast) share one clock and reset. Frames are
// recorded one sample per clock and compared against waveforms built from
// the expected byte lists.
module tb_uart_readback_tx;

    typedef struct {
        int              sel;
        int              nbytes;
        logic [2:0][7:0] regs;
        logic [3:0][7:0] exp_bytes;
        int              dur;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_readback_tx_if if_a ();
    uart_readback_tx_if if_b ();
    uart_readback_tx_if if_c ();
    uart_readback_tx_if if_d ();

    uart_readback_tx #(.CLKS_PER_BIT(4), .NUM_BYTES(3), .SEND_SYNC(1), .SYNC_BYTE(8'hA5))
        dut_a (.clk(clk), .reset(reset), .bus(if_a));
    uart_readback_tx #(.CLKS_PER_BIT(4), .NUM_BYTES(3), .SEND_SYNC(0), .SYNC_BYTE(8'hA5))
        dut_b (.clk(clk), .reset(reset), .bus(if_b));
    uart_readback_tx
        dut_c (.clk(clk), .reset(reset), .bus(if_c));
    uart_readback_tx #(.CLKS_PER_BIT(4), .NUM_BYTES(60), .SEND_SYNC(1), .SYNC_BYTE(8'hA5))
        dut_d (.clk(clk), .reset(reset), .bus(if_d));

    logic [7:0] mem_a [0:127];
    logic [7:0] mem_b [0:127];
    logic [7:0] mem_c [0:127];
    logic [7:0] mem_d [0:127];

    assign if_a.rd_data = mem_a[if_a.rd_idx];
    assign if_b.rd_data = mem_b[if_b.rd_idx];
    assign if_c.rd_data = mem_c[if_c.rd_idx];
    assign if_d.rd_data = mem_d[if_d.rd_idx];

    int         sel;
    logic       m_tx;
    logic       m_busy;
    logic       m_done;
    logic [6:0] m_idx;

    always_comb begin
        m_tx   = if_d.tx;
        m_busy = if_d.busy;
        m_done = if_d.done;
        m_idx  = if_d.rd_idx;
        case (sel)
            0: begin m_tx = if_a.tx; m_busy = if_a.busy; m_done = if_a.done; m_idx = if_a.rd_idx; end
            1: begin m_tx = if_b.tx; m_busy = if_b.busy; m_done = if_b.done; m_idx = if_b.rd_idx; end
            2: begin m_tx = if_c.tx; m_busy = if_c.busy; m_done = if_c.done; m_idx = if_c.rd_idx; end
            default: begin end
        endcase
    end

    logic [7:0] exp_q [0:63];
    int         checks;
    int         passes;
    vec_t       vecs [0:3];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    task automatic set_start(input int s, input logic v);
        case (s)
            0: if_a.start = v;
            1: if_b.start = v;
            2: if_c.start = v;
            default: if_d.start = v;
        endcase
    endtask

    task automatic load_mem(input int s, input int idx, input logic [7:0] val);
        case (s)
            0: mem_a[idx] = val;
            1: mem_b[idx] = val;
            2: mem_c[idx] = val;
            default: mem_d[idx] = val;
        endcase
    endtask

    // Pulse start, record tx per clock and check the first nchk bytes.
    // With full set, also check done timing, busy and the rd_idx sequence.
    task automatic run_frame(input int s, input int cpb, input int nchk, input int dur,
                             input bit full, input int max_idx, input int poke_n,
                             input bit poke_done, input string tag);
        int n, fall_n, done_n, done_cnt, busy_bad, post_bad, idx_bad;
        int nsamp, limit, bad, frame_err, b, p, base;
        logic e;
        logic [7:0] val;
        logic smp[$];
        logic [6:0] idx_q[$];
        nsamp = nchk * 10 * cpb;
        limit = full ? dur + 10 : 2 + nsamp;
        @(negedge clk);
        set_start(s, 1'b1);
        @(negedge clk);
        set_start(s, 1'b0);
        check({tag, "_busy_after_start"}, int'(m_busy), 1);
        n = 0; fall_n = -1; done_n = -1; done_cnt = 0; busy_bad = 0; post_bad = 0;
        idx_q.push_back(m_idx);
        while (n < limit) begin
            @(negedge clk);
            n++;
            set_start(s, 1'b0);
            if (n == poke_n) set_start(s, 1'b1);
            if (!m_tx && fall_n < 0) fall_n = n;
            if (n >= 2 && smp.size() < nsamp) smp.push_back(m_tx);
            if (m_done) begin
                done_cnt++;
                if (done_n < 0) begin
                    done_n = n;
                    if (poke_done) set_start(s, 1'b1);
                end
            end
            if (full) begin
                if (done_n < 0 && !m_busy) busy_bad++;
                if (done_n >= 0 && (m_busy || !m_tx)) post_bad++;
            end
            if (m_idx != idx_q[$]) idx_q.push_back(m_idx);
        end
        set_start(s, 1'b0);
        check({tag, "_tx_fall_latency"}, fall_n, 2);
        bad = 0;
        for (int j = 0; j < nsamp; j++) begin
            b = j / (10 * cpb);
            p = (j % (10 * cpb)) / cpb;
            if (p == 0) e = 1'b0;
            else if (p == 9) e = 1'b1;
            else e = exp_q[b][p-1];
            if (j >= smp.size()) bad++;
            else if (smp[j] !== e) bad++;
        end
        check({tag, "_wave_bad_samples"}, bad, 0);
        frame_err = 0;
        if (smp.size() == nsamp) begin
            for (int k = 0; k < nchk; k++) begin
                base = k * 10 * cpb;
                val = 8'h00;
                for (int i = 0; i < 8; i++) val[i] = smp[base + (1 + i) * cpb + cpb / 2];
                if (smp[base + cpb / 2] !== 1'b0 || smp[base + 9 * cpb + cpb / 2] !== 1'b1)
                    frame_err++;
                check($sformatf("%s_byte%0d", tag, k), int'(val), int'(exp_q[k]));
            end
        end else begin
            frame_err = nchk;
        end
        check({tag, "_framing_errors"}, frame_err, 0);
        if (full) begin
            check({tag, "_done_count"}, done_cnt, 1);
            check({tag, "_done_cycle"}, done_n, dur);
            check({tag, "_busy_drop_early"}, busy_bad, 0);
            check({tag, "_after_done_bad"}, post_bad, 0);
            idx_bad = 0;
            if (idx_q.size() != max_idx + 1) idx_bad++;
            for (int i = 0; i < idx_q.size(); i++) if (int'(idx_q[i]) != i) idx_bad++;
            check({tag, "_rd_idx_seq_bad"}, idx_bad, 0);
        end
    endtask

    initial begin
        int bad;
        checks = 0;
        passes = 0;
        sel    = 0;
        reset  = 1'b1;
        if_a.start = 1'b0; if_b.start = 1'b0; if_c.start = 1'b0; if_d.start = 1'b0;
        for (int i = 0; i < 128; i++) begin
            mem_a[i] = 8'h00; mem_b[i] = 8'h00;
            mem_c[i] = 8'(i) ^ 8'h5A; mem_d[i] = 8'(i) ^ 8'h5A;
        end
        for (int i = 0; i < 64; i++) exp_q[i] = 8'h00;

        vecs[0] = '{sel: 0, nbytes: 4, regs: {8'hFF, 8'h81, 8'h3C},
                    exp_bytes: {8'hFF, 8'h81, 8'h3C, 8'hA5}, dur: 161};
        vecs[1] = '{sel: 0, nbytes: 4, regs: {8'h5A, 8'hFF, 8'h00},
                    exp_bytes: {8'h5A, 8'hFF, 8'h00, 8'hA5}, dur: 161};
        vecs[2] = '{sel: 1, nbytes: 3, regs: {8'h55, 8'h80, 8'h01},
                    exp_bytes: {8'h00, 8'h55, 8'h80, 8'h01}, dur: 121};
        vecs[3] = '{sel: 1, nbytes: 3, regs: {8'hF0, 8'h0F, 8'hAA},
                    exp_bytes: {8'h00, 8'hF0, 8'h0F, 8'hAA}, dur: 121};

        // Reset held for three edges, then idle checks.
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset_tx", int'(if_a.tx), 1);
        check("reset_busy", int'(if_a.busy), 0);
        check("reset_done", int'(if_a.done), 0);
        check("reset_rd_idx", int'(if_a.rd_idx), 0);
        check("reset_tx_default_params", int'(if_c.tx), 1);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!if_a.tx || if_a.busy || if_a.done || !if_b.tx || !if_d.tx) bad++;
        end
        check("idle_activity", bad, 0);

        // Table-driven frames.
        for (int i = 0; i < 4; i++) begin
            sel = vecs[i].sel;
            for (int k = 0; k < 3; k++) load_mem(sel, k, vecs[i].regs[k]);
            for (int k = 0; k < 4; k++) exp_q[k] = vecs[i].exp_bytes[k];
            run_frame(sel, 4, vecs[i].nbytes, vecs[i].dur, 1'b1, 2, -1, 1'b0,
                      $sformatf("vec%0d", i));
            repeat (3) @(negedge clk);
        end

        // start mid-byte 1 and again during the done pulse: one frame only.
        sel = 0;
        mem_a[0] = 8'h3C; mem_a[1] = 8'h81; mem_a[2] = 8'hFF;
        exp_q[0] = 8'hA5; exp_q[1] = 8'h3C; exp_q[2] = 8'h81; exp_q[3] = 8'hFF;
        run_frame(0, 4, 4, 161, 1'b1, 2, 50, 1'b1, "busy_start");
        repeat (3) @(negedge clk);

        // Reset during data bit 3 of the third byte on the line (0x81).
        @(negedge clk);
        set_start(0, 1'b1);
        @(negedge clk);
        set_start(0, 1'b0);
        repeat (98) @(negedge clk);
        check("pre_reset_tx_bit3", int'(if_a.tx), 0);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_tx", int'(if_a.tx), 1);
        check("midreset_busy", int'(if_a.busy), 0);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (if_a.done || !if_a.tx || if_a.busy) bad++;
        end
        check("midreset_quiet", bad, 0);
        run_frame(0, 4, 4, 161, 1'b1, 2, -1, 1'b0, "after_reset");
        repeat (3) @(negedge clk);

        // Default parameters at 115200 baud: header plus first pattern bytes.
        exp_q[0] = 8'hA5;
        for (int i = 0; i < 60; i++) exp_q[i + 1] = 8'(i) ^ 8'h5A;
        sel = 2;
        run_frame(2, 434, 4, 0, 1'b0, 0, -1, 1'b0, "dflt");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("dflt_reset_tx", int'(if_c.tx), 1);
        check("dflt_reset_busy", int'(if_c.busy), 0);

        // Full 60-byte pattern frame at 4 clocks per bit.
        sel = 3;
        run_frame(3, 4, 61, 2441, 1'b1, 59, -1, 1'b0, "pat60");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
